// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-outstanding AXI-Lite master turning command/response
// transactions into AXI-Lite writes and reads, with a per-transaction timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a command (o_cmd_ready = 1)
// WR_REQ   | AW and W valids outstanding, each retired independently
// WR_RSP   | bready high, waiting for the B response
// RD_REQ   | arvalid high, waiting for arready
// RD_RSP   | rready high, waiting for the R beat
// RSP      | response presented until i_rsp_ready
module axi_lite_master_bridge #(
    parameter int AXI_LITE_AW    = 32,
    parameter int AXI_LITE_DW    = 32,
    parameter int AXI_LITE_STRB  = AXI_LITE_DW/8,
    parameter int AXI_LITE_RSPW  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_wr,
    input  logic [AXI_LITE_AW-1:0]   i_cmd_addr,
    input  logic [AXI_LITE_DW-1:0]   i_cmd_wdata,
    input  logic [AXI_LITE_STRB-1:0] i_cmd_wstrb,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_wr,
    output logic [AXI_LITE_DW-1:0]   o_rsp_rdata,
    output logic [AXI_LITE_RSPW-1:0] o_rsp_resp,
    output logic                     o_rsp_timeout,
    output logic [AXI_LITE_AW-1:0]   o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [AXI_LITE_DW-1:0]   o_axi_wdata,
    output logic [AXI_LITE_STRB-1:0] o_axi_wstrb,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [AXI_LITE_RSPW-1:0] i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic [AXI_LITE_AW-1:0]   o_axi_araddr,
    output logic                     o_axi_arvalid,
    input  logic                     i_axi_arready,
    input  logic [AXI_LITE_DW-1:0]   i_axi_rdata,
    input  logic [AXI_LITE_RSPW-1:0] i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RSP, S_RD_REQ, S_RD_RSP, S_RSP
    } state_t;

    localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT_CYCLES);
    localparam logic [AXI_LITE_RSPW-1:0] RESP_TIMEOUT = AXI_LITE_RSPW'(2);

    state_t r_state, w_state_nxt;

    logic [AXI_LITE_AW-1:0]   r_addr;
    logic [AXI_LITE_DW-1:0]   r_wdata;
    logic [AXI_LITE_STRB-1:0] r_wstrb;
    logic                     r_awvalid, r_wvalid, r_arvalid;
    logic                     r_aw_done, r_w_done;
    logic [TCW-1:0]           r_tmo_cnt;
    logic                     r_rsp_wr, r_rsp_timeout;
    logic [AXI_LITE_DW-1:0]   r_rsp_rdata;
    logic [AXI_LITE_RSPW-1:0] r_rsp_resp;

    logic           w_accept, w_busy, w_complete, w_tmo_hit;
    logic           w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_wr_req_done;
    logic [TCW-1:0] w_tmo_elapsed;

    assign w_accept      = i_cmd_valid && (r_state == S_IDLE);
    assign w_aw_hs       = r_awvalid && i_axi_awready;
    assign w_w_hs        = r_wvalid && i_axi_wready;
    assign w_ar_hs       = r_arvalid && i_axi_arready;
    assign w_b_hs        = (r_state == S_WR_RSP) && i_axi_bvalid;
    assign w_r_hs        = (r_state == S_RD_RSP) && i_axi_rvalid;
    assign w_wr_req_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_busy        = (r_state == S_WR_REQ) || (r_state == S_WR_RSP) ||
                           (r_state == S_RD_REQ) || (r_state == S_RD_RSP);

    // Elapsed count includes the current cycle, so expiry lands TIMEOUT_CYCLES cycles after accept.
    assign w_tmo_elapsed = r_tmo_cnt + TCW'(1);

    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            S_WR_REQ: w_complete = w_wr_req_done;
            S_WR_RSP: w_complete = w_b_hs;
            S_RD_REQ: w_complete = w_ar_hs;
            S_RD_RSP: w_complete = w_r_hs;
            default:  w_complete = 1'b0;
        endcase
    end

    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_busy && !w_complete &&
                       (w_tmo_elapsed == TMO_LIMIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_cmd_valid) w_state_nxt = i_cmd_wr ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ: if (w_tmo_hit) w_state_nxt = S_RSP;
                      else if (w_wr_req_done) w_state_nxt = S_WR_RSP;
            S_WR_RSP: if (w_tmo_hit || w_b_hs) w_state_nxt = S_RSP;
            S_RD_REQ: if (w_tmo_hit) w_state_nxt = S_RSP;
                      else if (w_ar_hs) w_state_nxt = S_RD_RSP;
            S_RD_RSP: if (w_tmo_hit || w_r_hs) w_state_nxt = S_RSP;
            S_RSP:    if (i_rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_tmo_cnt     <= '0;
            r_rsp_wr      <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
        end else if (w_accept) begin
            r_addr        <= i_cmd_addr;
            r_wdata       <= i_cmd_wdata;
            r_wstrb       <= i_cmd_wstrb;
            r_awvalid     <= i_cmd_wr;
            r_wvalid      <= i_cmd_wr;
            r_arvalid     <= !i_cmd_wr;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_tmo_cnt     <= '0;
            r_rsp_wr      <= i_cmd_wr;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_busy) r_tmo_cnt <= w_tmo_elapsed;
            if (w_tmo_hit) begin
                // Dropping a pending valid breaks AXI rules; acceptable only as a debug escape.
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rsp_resp    <= RESP_TIMEOUT;
                r_rsp_timeout <= 1'b1;
                r_rsp_rdata   <= '0;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end
                if (w_ar_hs) r_arvalid <= 1'b0;
                if (w_b_hs) begin
                    r_rsp_resp  <= i_axi_bresp;
                    r_rsp_rdata <= '0;
                end
                if (w_r_hs) begin
                    r_rsp_resp  <= i_axi_rresp;
                    r_rsp_rdata <= i_axi_rdata;
                end
            end
        end
    end

    assign o_cmd_ready   = (r_state == S_IDLE);
    assign o_rsp_valid   = (r_state == S_RSP);
    assign o_rsp_wr      = r_rsp_wr;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_axi_awaddr  = r_addr;
    assign o_axi_araddr  = r_addr;
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_bready  = (r_state == S_WR_RSP);
    assign o_axi_rready  = (r_state == S_RD_RSP);
endmodule
